// File: rtl/xbar_ingress_sched_pkg.sv
// Shared sizing and types for the crossbar ingress scheduler and its arbiters.
package xbar_ingress_sched_pkg;

    localparam int N_PORTS    = 4;
    localparam int PORT_IDX_W = 2;
    localparam int DEF_DATA_W = 8;
    localparam int TAG_W      = 2;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;
    typedef logic [N_PORTS-1:0]    port_mask_t;

    typedef struct packed {
        logic      valid;
        port_idx_t owner;
    } slot_t;

endpackage

// File: rtl/xbar_ingress_sched_rr_arb4.sv
// Combinational 4-way round-robin arbiter: the first requester at or after ptr wins.
module rr_arb4
    import xbar_ingress_sched_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx
);

    port_idx_t cand;

    // Scan from farthest to nearest so the nearest requester is the last writer.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        gnt  = '0;
        idx  = '0;
        cand = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            cand = ptr + port_idx_t'(k);
            if (req[cand]) begin
                gnt = port_mask_t'(1) << cand;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/xbar_ingress_sched.sv
// Ingress scheduler for the 4x4 mux crossbar: per-output round-robin grants into
// registered slots, driving ip0..ip3 and one-hot sel0..sel3 from flops only.
module xbar_ingress_sched
    import xbar_ingress_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        in_valid,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    input  logic [1:0]        in_dst0,
    input  logic [1:0]        in_dst1,
    input  logic [1:0]        in_dst2,
    input  logic [1:0]        in_dst3,
    output logic [3:0]        in_ready,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] ip0,
    output logic [DATA_W-1:0] ip1,
    output logic [DATA_W-1:0] ip2,
    output logic [DATA_W-1:0] ip3,
    output logic [3:0]        sel0,
    output logic [3:0]        sel1,
    output logic [3:0]        sel2,
    output logic [3:0]        sel3,
    output logic [3:0]        out_valid
);

    logic [DATA_W-1:0] data_in [N_PORTS];
    port_idx_t         dst_in  [N_PORTS];

    assign data_in[0] = in_data0;
    assign data_in[1] = in_data1;
    assign data_in[2] = in_data2;
    assign data_in[3] = in_data3;
    assign dst_in[0]  = in_dst0;
    assign dst_in[1]  = in_dst1;
    assign dst_in[2]  = in_dst2;
    assign dst_in[3]  = in_dst3;

    slot_t             slot_q   [N_PORTS];
    slot_t             slot_d   [N_PORTS];
    port_idx_t         rr_ptr_q [N_PORTS];
    port_idx_t         rr_ptr_d [N_PORTS];
    logic [DATA_W-1:0] ip_q     [N_PORTS];
    logic [DATA_W-1:0] ip_d     [N_PORTS];

    port_mask_t busy;
    port_mask_t can_load;
    port_mask_t req [N_PORTS];
    port_mask_t gnt [N_PORTS];
    port_idx_t  win [N_PORTS];
    port_mask_t sel [N_PORTS];
    port_mask_t col [N_PORTS];

    // A busy input still has its word parked in a stalled slot, so ip_i must hold.
    always_comb begin
        busy     = '0;
        can_load = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            can_load[j] = !slot_q[j].valid || out_ready[j];
            if (slot_q[j].valid && !out_ready[j]) busy[slot_q[j].owner] = 1'b1;
        end
    end

    always_comb begin
        for (int j = 0; j < N_PORTS; j++) begin
            req[j] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                req[j][i] = can_load[j] && in_valid[i] && !busy[i]
                            && (dst_in[i] == port_idx_t'(j));
            end
        end
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_arb
        rr_arb4 u_arb (
            .req (req[g]),
            .ptr (rr_ptr_q[g]),
            .gnt (gnt[g]),
            .idx (win[g])
        );
    end

    always_comb begin
        in_ready = '0;
        for (int j = 0; j < N_PORTS; j++) in_ready = in_ready | gnt[j];
        if (rst) in_ready = '0;
    end

    always_comb begin
        slot_d   = slot_q;
        rr_ptr_d = rr_ptr_q;
        ip_d     = ip_q;
        for (int j = 0; j < N_PORTS; j++) begin
            if (|gnt[j]) begin
                slot_d[j].valid = 1'b1;
                slot_d[j].owner = win[j];
                rr_ptr_d[j]     = win[j] + 2'd1;
            end else if (slot_q[j].valid && out_ready[j]) begin
                slot_d[j].valid = 1'b0;
            end
        end
        for (int i = 0; i < N_PORTS; i++) begin
            if (in_ready[i]) ip_d[i] = data_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PORTS; i++) begin
                // NOTE: non-blocking so every flop updates from pre-edge values.
                slot_q[i]   <= '0;
                rr_ptr_q[i] <= '0;
                // NOTE: ip registers are plain flops feeding the crossbar, so they are reset too.
                ip_q[i]     <= '0;
            end
        end else begin
            slot_q   <= slot_d;
            rr_ptr_q <= rr_ptr_d;
            ip_q     <= ip_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            sel[i] = '0;
            col[i] = '0;
        end
        for (int i = 0; i < N_PORTS; i++) begin
            for (int j = 0; j < N_PORTS; j++) begin
                sel[i][j] = slot_q[j].valid && (slot_q[j].owner == port_idx_t'(i));
                col[j][i] = sel[i][j];
            end
        end
        for (int j = 0; j < N_PORTS; j++) out_valid[j] = slot_q[j].valid;
    end

    assign ip0  = ip_q[0];
    assign ip1  = ip_q[1];
    assign ip2  = ip_q[2];
    assign ip3  = ip_q[3];
    assign sel0 = sel[0];
    assign sel1 = sel[1];
    assign sel2 = sel[2];
    assign sel3 = sel[3];

    for (genvar g = 0; g < N_PORTS; g++) begin : g_chk
        a_sel_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(sel[g]));
        a_col_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(col[g]));
        a_valid_owner : assert property (@(posedge clk) disable iff (rst)
                                         out_valid[g] |-> $onehot(col[g]));
    end

endmodule

// File: tb/tb_xbar_ingress_sched.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// slot/pointer reference model of the scheduling rules.
module tb_xbar_ingress_sched;

    logic       clk;
    logic       rst;
    logic [3:0] src_valid;
    logic [7:0] src_data [4];
    logic [1:0] src_dst  [4];
    logic [3:0] in_ready;
    logic [3:0] out_ready;
    logic [7:0] ip0, ip1, ip2, ip3;
    logic [3:0] sel0, sel1, sel2, sel3;
    logic [3:0] out_valid;

    xbar_ingress_sched #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (src_valid),
        .in_data0  (src_data[0]),
        .in_data1  (src_data[1]),
        .in_data2  (src_data[2]),
        .in_data3  (src_data[3]),
        .in_dst0   (src_dst[0]),
        .in_dst1   (src_dst[1]),
        .in_dst2   (src_dst[2]),
        .in_dst3   (src_dst[3]),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .ip0       (ip0),
        .ip1       (ip1),
        .ip2       (ip2),
        .ip3       (ip3),
        .sel0      (sel0),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] ip_w  [4];
    logic [3:0] sel_w [4];
    assign ip_w[0]  = ip0;
    assign ip_w[1]  = ip1;
    assign ip_w[2]  = ip2;
    assign ip_w[3]  = ip3;
    assign sel_w[0] = sel0;
    assign sel_w[1] = sel1;
    assign sel_w[2] = sel2;
    assign sel_w[3] = sel3;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one slot per output, one pointer per output, one held word per input.
    bit         m_vld [4];
    int         m_own [4];
    int         m_ptr [4];
    logic [7:0] m_ip  [4];
    int         m_win [4];
    logic [3:0] m_rdy;
    logic [3:0] seen_rdy;

    function automatic bit m_busy(int i);
        for (int j = 0; j < 4; j++)
            if (m_vld[j] && m_own[j] == i && !out_ready[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compute_model();
        m_rdy = '0;
        for (int j = 0; j < 4; j++) m_win[j] = -1;
        if (!rst) begin
            for (int j = 0; j < 4; j++) begin
                if (!m_vld[j] || out_ready[j]) begin
                    for (int k = 0; k < 4; k++) begin
                        int i;
                        i = (m_ptr[j] + k) % 4;
                        if (src_valid[i] && int'(src_dst[i]) == j && !m_busy(i)) begin
                            m_win[j] = i;
                            m_rdy[i] = 1'b1;
                            break;
                        end
                    end
                end
            end
        end
    endtask

    task automatic update_model();
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                m_vld[j] = 1'b0;
                m_own[j] = 0;
                m_ptr[j] = 0;
                m_ip[j]  = 8'h00;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (m_win[j] >= 0) begin
                    m_ip[m_win[j]] = src_data[m_win[j]];
                    m_own[j] = m_win[j];
                    m_vld[j] = 1'b1;
                    m_ptr[j] = (m_win[j] + 1) % 4;
                end else if (m_vld[j] && out_ready[j]) begin
                    m_vld[j] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_state();
        logic [3:0] exp_ov;
        logic [3:0] exp_sel;
        exp_ov = '0;
        for (int j = 0; j < 4; j++) exp_ov[j] = m_vld[j];
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        for (int i = 0; i < 4; i++) begin
            exp_sel = '0;
            for (int j = 0; j < 4; j++) exp_sel[j] = m_vld[j] && m_own[j] == i;
            check($sformatf("sel%0d", i), 32'(sel_w[i]), 32'(exp_sel));
            check($sformatf("ip%0d", i), 32'(ip_w[i]), 32'(m_ip[i]));
        end
    endtask

    // One clock: check grants and state mid-cycle, then advance model and sources.
    task automatic step();
        @(negedge clk);
        compute_model();
        seen_rdy = in_ready;
        check("in_ready", 32'(in_ready), 32'(m_rdy));
        compare_state();
        @(posedge clk);
        #1;
        update_model();
        for (int i = 0; i < 4; i++) if (m_rdy[i]) src_valid[i] = 1'b0;
    endtask

    // Crossbar model: fixed mux chain, output carries {input tag, data}.
    function automatic logic [9:0] xbar_sd(int j);
        logic [9:0] sd;
        sd = '0;
        for (int i = 3; i >= 0; i--) if (sel_w[i][j]) sd = {2'(i), ip_w[i]};
        return sd;
    endfunction

    function automatic logic [3:0] column(int j);
        logic [3:0] c;
        for (int i = 0; i < 4; i++) c[i] = sel_w[i][j];
        return c;
    endfunction

    initial begin
        rst       = 1'b1;
        src_valid = 4'hF;
        out_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            src_data[i] = 8'h00;
            src_dst[i]  = 2'd0;
        end

        // Reset: no grants while rst is high, outputs cleared after the first edge.
        @(negedge clk);
        check("rst_ready_first", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        update_model();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_sel", 32'({sel3, sel2, sel1, sel0}), 32'h0);
        check("rst_ip", {ip3, ip2, ip1, ip0}, 32'h0);
        step();

        // No contention: two inputs to two different outputs.
        rst         = 1'b0;
        out_ready   = 4'hF;
        src_valid   = 4'b0011;
        src_data[0] = 8'hA5; src_dst[0] = 2'd2;
        src_data[1] = 8'h3C; src_dst[1] = 2'd0;
        step();
        check("nc_sel0", 32'(sel0), 32'b0100);
        check("nc_sel1", 32'(sel1), 32'b0001);
        check("nc_ip0", 32'(ip0), 32'hA5);
        check("nc_ip1", 32'(ip1), 32'h3C);
        check("nc_out_valid", 32'(out_valid), 32'b0101);
        check("nc_sd2", 32'(xbar_sd(2)), 32'h0A5);
        check("nc_sd0", 32'(xbar_sd(0)), 32'h13C);
        src_valid = 4'b0000;
        step();

        // Round-robin on output 1 with every input requesting continuously.
        for (int k = 0; k < 5; k++) begin
            src_valid = 4'hF;
            for (int i = 0; i < 4; i++) begin
                src_dst[i]  = 2'd1;
                src_data[i] = 8'h10 + 8'(i);
            end
            step();
            check($sformatf("rr_winner_%0d", k), 32'(column(1)), 32'(4'b0001 << (k % 4)));
            check($sformatf("rr_no_bubble_%0d", k), 32'(out_valid[1]), 32'h1);
        end

        // Reset mid-stream with grants pending.
        src_valid = 4'hF;
        rst = 1'b1;
        step();
        check("mid_rst_ready", 32'(seen_rdy), 32'h0);
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        check("mid_rst_ip", {ip3, ip2, ip1, ip0}, 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_winner", 32'(column(1)), 32'b0001);

        // Backpressure: input 2 parked in stalled slot 1 cannot move to output 3.
        src_valid = 4'b0000;
        step();
        src_valid = 4'b0100; src_dst[2] = 2'd1; src_data[2] = 8'h42;
        step();
        check("bp_setup_sel2", 32'(sel2), 32'b0010);
        out_ready = 4'b1101;
        src_valid = 4'b0100; src_dst[2] = 2'd3; src_data[2] = 8'h77;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("bp_ready_%0d", k), 32'(seen_rdy[2]), 32'h0);
            check($sformatf("bp_sel2_%0d", k), 32'(sel2), 32'b0010);
            check($sformatf("bp_ip2_%0d", k), 32'(ip2), 32'h42);
        end
        out_ready = 4'hF;
        step();
        check("bp_release_ready", 32'(seen_rdy), 32'b0100);
        check("bp_release_sel2", 32'(sel2), 32'b1000);
        check("bp_release_ip2", 32'(ip2), 32'h77);

        // Independence: input 3 stuck on output 1 must not slow input 0 on output 0.
        src_valid = 4'b0000;
        step();
        src_valid = 4'b1000; src_dst[3] = 2'd1; src_data[3] = 8'h33;
        step();
        out_ready = 4'b1101;
        src_valid = 4'b1000; src_dst[3] = 2'd2; src_data[3] = 8'h99;
        src_dst[0] = 2'd0;
        for (int k = 0; k < 4; k++) begin
            src_valid[0] = 1'b1;
            src_data[0]  = 8'hC0 + 8'(k);
            step();
            check($sformatf("ind_ready_%0d", k), 32'(seen_rdy), 32'b0001);
            check($sformatf("ind_ip0_%0d", k), 32'(ip0), 32'(8'hC0 + 8'(k)));
            check($sformatf("ind_sel3_%0d", k), 32'(sel3), 32'b0010);
        end

        // Randomized traffic with sporadic resets and backpressure.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            out_ready = 4'($urandom) | 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                if (!src_valid[i] && $urandom_range(0, 9) < 7) begin
                    src_valid[i] = 1'b1;
                    src_data[i]  = 8'($urandom);
                    src_dst[i]   = 2'($urandom);
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
